hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_W, default 4, register-address width; NUM_REGS = 2**REG_W.
REQ-002 SHALL have parameter DEPTH, default 2, number of tracked in-flight stages between ID and WB (EX..MEM), range 1..4.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 id_valid  input  1  an instruction is present in ID.
REQ-007 src1, src2  input  REG_W each  ID source registers.
REQ-008 two_src  input  1  src2 is a real operand.
REQ-009 id_dest  input  REG_W  ID destination register.
REQ-010 id_wb_en  input  1  ID instruction writes id_dest.
REQ-011 id_mem_read  input  1  ID instruction is a load.
REQ-012 fwd_en  input  1  forwarding present; only load-use hazards stall.
REQ-013 freeze  input  1  whole pipeline held (memory wait).
REQ-014 flush  input  1  branch taken; ID instruction is killed.
REQ-015 hazard  output  1  stall IF/ID and insert a bubble into EX this cycle.
REQ-016 hazard_stage  output  2  index of youngest matching tracked stage, 0 when hazard=0.
REQ-017 busy_vec  output  NUM_REGS  bit r set when any tracked valid entry has wb_en and dest==r.
REQ-018 stall_cnt  output  CNT_W  count of cycles with hazard=1 and freeze=0.

Function
REQ-019 SHALL hold a DEPTH-entry shift register; entry k = {valid, dest, wb_en, mem_read}; entry 0 = EX, entry DEPTH-1 = last stage before WB.
REQ-020 Entry k match: valid & wb_en & id_valid & (dest==src1 | (two_src & dest==src2)).
REQ-021 fwd_en=0: hazard = OR of matches over all entries.
REQ-022 fwd_en=1: hazard = match of entry 0 AND entry 0 mem_read; other entries never cause hazard.
REQ-023 hazard, hazard_stage, busy_vec SHALL be combinational from current state and inputs (zero latency).
REQ-024 Advance when freeze=0: entry k+1 <= entry k; entry DEPTH-1 retires.
REQ-025 On advance, entry 0 <= ID instruction if id_valid & !hazard & !flush, else bubble (valid=0).
REQ-026 freeze=1: all entries and stall_cnt hold; hazard still reported combinationally.
REQ-027 flush and hazard in same cycle: bubble inserted; flush takes precedence; stall_cnt still increments.
REQ-028 hazard_stage SHALL report the lowest matching k (youngest producer).
REQ-029 stall_cnt SHALL saturate at all-ones, never wrap.
REQ-030 Register 0 SHALL receive no special treatment (all registers tracked identically).

Reset
REQ-031 rst=1 at clock edge: all entries valid=0, stall_cnt=0; hazard=0, hazard_stage=0, busy_vec=0 the following cycle.
REQ-032 rst SHALL override freeze and flush; a reset mid-stall discards all tracked writes.

Structure
REQ-033 Entry record type and DEPTH/REG_W defaults SHALL live in shared package hazard_pkg.
REQ-034 Per-entry comparator SHALL be sub-module hazard_match (entry fields, src1, src2, two_src -> match), instantiated DEPTH times by generate.

Verification
REQ-035 fwd_en=0, ADD dest=3 issued, next ID src1=3 -> hazard=1, hazard_stage=0; one cycle later hazard=1, hazard_stage=1; then hazard=0; stall_cnt=2.
REQ-036 fwd_en=1, LDR dest=5 issued, next ID src2=5, two_src=1 -> exactly one stall cycle; with two_src=0 -> no stall.
REQ-037 fwd_en=1, non-load dest=7 then consumer src1=7 -> hazard=0, stall_cnt unchanged.
REQ-038 Hazard active, freeze=1 for 3 cycles -> hazard stays 1, entries and stall_cnt frozen; release -> normal drain.
REQ-039 flush=1 with id_wb_en=1, id_dest=9 -> entry 0 bubble, busy_vec[9]=0 next cycle.
REQ-040 CNT_W=4, force 20 stall cycles -> stall_cnt=15; rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the register-hazard scoreboard.
// The tracked destination field is sized to REG_W_MAX so one entry type serves every REG_W <= 8.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned REG_W_MAX = 8;
  localparam int unsigned STAGE_W   = 2;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dest;
    logic                 wb_en;
    logic                 mem_read;
  } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Single-entry RAW comparator: does this in-flight producer write a source of the ID instruction?
module hazard_match
  import hazard_pkg::*;
(
  input  entry_t               entry,
  input  logic [REG_W_MAX-1:0] src1,
  input  logic [REG_W_MAX-1:0] src2,
  input  logic                 two_src,
  output logic                 match
);

  always_comb begin
    match = entry.valid & entry.wb_en &
            ((entry.dest == src1) | (two_src & (entry.dest == src2)));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks EX..MEM writers, raises stall on RAW hazards,
// and counts stall cycles. REG_W must not exceed hazard_pkg::REG_W_MAX.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_W-1:0]      src1,
  input  logic [REG_W-1:0]      src2,
  input  logic                  two_src,
  input  logic [REG_W-1:0]      id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  fwd_en,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard,
  output logic [STAGE_W-1:0]    hazard_stage,
  output logic [(2**REG_W)-1:0] busy_vec,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_W;

  entry_t               ent_q [DEPTH];
  entry_t               id_entry;
  logic [DEPTH-1:0]     match_raw;
  logic [DEPTH-1:0]     cause;
  logic [REG_W_MAX-1:0] src1_x;
  logic [REG_W_MAX-1:0] src2_x;

  assign src1_x = REG_W_MAX'(src1);
  assign src2_x = REG_W_MAX'(src2);

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_match
    hazard_match u_match (
      .entry   (ent_q[g]),
      .src1    (src1_x),
      .src2    (src2_x),
      .two_src (two_src),
      .match   (match_raw[g])
    );
  end

  // With forwarding only a load sitting in EX can stall; otherwise any tracked writer does.
  always_comb begin
    cause        = '0;
    hazard       = 1'b0;
    hazard_stage = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      cause[k] = match_raw[k] & id_valid &
                 (~fwd_en | ((k == 0) & ent_q[k].mem_read));
    end
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (cause[k]) begin
        hazard       = 1'b1;
        hazard_stage = STAGE_W'(k);
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (ent_q[k].valid && ent_q[k].wb_en && (ent_q[k].dest == REG_W_MAX'(r))) begin
          busy_vec[r] = 1'b1;
        end
      end
    end
  end

  // Stalled or flushed ID instructions become bubbles in EX.
  always_comb begin
    id_entry = '0;
    if (id_valid && !hazard && !flush) begin
      id_entry.valid    = 1'b1;
      id_entry.dest     = REG_W_MAX'(id_dest);
      id_entry.wb_en    = id_wb_en;
      id_entry.mem_read = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        ent_q[k] <= '0;
      end
      stall_cnt <= '0;
    end else if (!freeze) begin
      ent_q[0] <= id_entry;
      for (int k = 1; k < int'(DEPTH); k++) begin
        ent_q[k] <= ent_q[k-1];
      end
      if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
